// File: rtl/bcd_display_pkg.sv
// Shared constants for the two-digit BCD display multiplexer:
// active-high 7-segment patterns (gfedcba), the blank pattern, the
// largest legal BCD digit and a helper that sizes the refresh prescaler.
package bcd_display_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width of a counter that must hold 0..div-1; never narrower than one bit.
  function automatic int divWidth(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_display_mux_if.sv
// Bus between the upstream decade counter / board pins and the display mux.
// The master side drives the counter sample; the slave side (the mux) drives
// the display pins and status flags.
interface bcd_display_mux_if;

  logic [3:0] cnt_in;
  logic       vld_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] tens;
  logic       ovf;
  logic       bad_code;

  modport master (
    output cnt_in, vld_in,
    input  seg, an, tens, ovf, bad_code
  );

  modport slave (
    input  cnt_in, vld_in,
    output seg, an, tens, ovf, bad_code
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high 7-segment pattern (gfedcba).
// Codes above 9 produce a dark digit rather than a misleading glyph.
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup of the lit segments for one digit.
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit BCD display multiplexer. Samples the units digit from an upstream
// decade counter, derives the tens digit by spotting 9->0 wraps, and drives
// both digits onto one 7-segment bus with alternating anode enables.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the tens digit while it
// is 0 (the anode keeps toggling so brightness of the units digit is unchanged).
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int REFRESH_HZ     = 1_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_display_mux_if.slave   bus
);

  localparam int DIV = CLK_HZ / (2 * REFRESH_HZ);
  localparam int PW  = divWidth(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  localparam logic [6:0] SEG_DARK = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0] AN_DARK  = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  logic [3:0]    units_q, units_d;
  logic [3:0]    prev_q, prev_d;
  logic [3:0]    tens_q, tens_d;
  logic          ovf_q, ovf_d;
  logic          bad_q, bad_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  logic [3:0]    digit;
  logic [6:0]    litPattern;

  bcd_to_7seg u_dec (
    .bcd_i (digit),
    .seg_o (litPattern)
  );

  // Counter capture: accept legal samples, flag illegal ones, bump tens on a 9->0 wrap.
  always_comb begin
    units_d = units_q;
    prev_d  = prev_q;
    tens_d  = tens_q;
    ovf_d   = 1'b0;
    bad_d   = bad_q;
    if (bus.vld_in) begin
      if (bus.cnt_in > BCD_MAX) begin
        bad_d = 1'b1;
      end else begin
        units_d = bus.cnt_in;
        prev_d  = bus.cnt_in;
        if (bus.cnt_in == 4'd0 && prev_q == BCD_MAX) begin
          if (tens_q == BCD_MAX) begin
            tens_d = 4'd0;
            ovf_d  = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end
      end
    end
  end

  // Free-running refresh prescaler; flips the digit select once per DIV clocks.
  always_comb begin
    presc_d = presc_q + PW'(1);
    sel_d   = sel_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      sel_d   = ~sel_q;
    end
  end

  // Pick the digit for the current select and form the pin-polarity outputs.
  always_comb begin
    digit = sel_q ? tens_q : units_q;
    seg_d = litPattern;
`ifdef LEADING_ZERO_BLANK_EN
    if (sel_q && tens_q == 4'd0) begin
      seg_d = SEG_OFF;
    end
`endif
    if (SEG_ACTIVE_LOW != 0) begin
      seg_d = ~seg_d;
    end
    an_d = sel_q ? 2'b10 : 2'b01;
    if (AN_ACTIVE_LOW != 0) begin
      an_d = ~an_d;
    end
  end

  // State and output registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      units_q <= 4'd0;
      prev_q  <= 4'd0;
      tens_q  <= 4'd0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      presc_q <= '0;
      sel_q   <= 1'b0;
      seg_q   <= SEG_DARK;
      an_q    <= AN_DARK;
    end else begin
      units_q <= units_d;
      prev_q  <= prev_d;
      tens_q  <= tens_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.tens     = tens_q;
  assign bus.ovf      = ovf_q;
  assign bus.bad_code = bad_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux at CLK_HZ=1000, REFRESH_HZ=100
// (five clocks per digit), default active-low polarities.
module tb_bcd_display_mux;

  localparam int DIV = 5;

  logic clk;
  logic rst;
  bcd_display_mux_if bus();

  bcd_display_mux #(
    .CLK_HZ         (1000),
    .REFRESH_HZ     (100),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  logic checkEn   = 1'b0;

  logic [6:0] segTable [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int         mUnits, mTens, mPrev, mEdges;
  logic       mOvf, mBad;
  logic [6:0] expSeg;
  logic [1:0] expAn;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference behaviour: digit values from the counting rules, and the shown
  // digit from how many clocks have elapsed since reset.
  always @(posedge clk) begin
    if (rst) begin
      mUnits = 0; mTens = 0; mPrev = 0; mOvf = 0; mBad = 0; mEdges = 0;
      expSeg = 7'h7F;
      expAn  = 2'b11;
    end else begin
      if (((mEdges / DIV) % 2) == 1) begin
        expAn  = 2'b01;
        expSeg = ~segTable[mTens];
`ifdef LEADING_ZERO_BLANK_EN
        if (mTens == 0) expSeg = 7'h7F;
`endif
      end else begin
        expAn  = 2'b10;
        expSeg = ~segTable[mUnits];
      end
      mEdges++;
      mOvf = 0;
      if (bus.vld_in) begin
        if (bus.cnt_in > 9) begin
          mBad = 1;
        end else begin
          if (bus.cnt_in == 0 && mPrev == 9) begin
            mOvf  = (mTens == 9);
            mTens = (mTens + 1) % 10;
          end
          mUnits = int'(bus.cnt_in);
          mPrev  = int'(bus.cnt_in);
        end
      end
    end
  end

  // Every cycle: DUT outputs against the reference.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("seg",      32'(bus.seg),      32'(expSeg));
      checkOutput("an",       32'(bus.an),       32'(expAn));
      checkOutput("tens",     32'(bus.tens),     32'(mTens));
      checkOutput("ovf",      32'(bus.ovf),      32'(mOvf));
      checkOutput("bad_code", 32'(bus.bad_code), 32'(mBad));
    end
  end

  // Drive one cycle of inputs (called at a falling edge) and wait one clock.
  task automatic applyStimulus(input logic [3:0] cnt, input logic vld);
    bus.cnt_in = cnt;
    bus.vld_in = vld;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'd0, 1'b0);
    applyStimulus(4'd0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic doWrap();
    applyStimulus(4'd9, 1'b1);
    applyStimulus(4'd0, 1'b1);
  endtask

  // Idle until the anodes show the wanted pattern, bounded.
  task automatic waitAn(input logic [1:0] want, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 4 * DIV; i++) begin
      if (bus.an == want) begin
        seen = 1'b1;
        break;
      end
      applyStimulus(4'd0, 1'b0);
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    bus.cnt_in = 4'd0;
    bus.vld_in = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state after two reset edges.
    checkOutput("rst_seg",  32'(bus.seg),      32'h7F);
    checkOutput("rst_an",   32'(bus.an),       32'h3);
    checkOutput("rst_tens", 32'(bus.tens),     32'h0);
    checkOutput("rst_ovf",  32'(bus.ovf),      32'h0);
    checkOutput("rst_bad",  32'(bus.bad_code), 32'h0);
    checkEn = 1'b1;
    rst = 1'b0;

    // First edge out of reset enables units; tens follows five edges later.
    applyStimulus(4'd0, 1'b0);
    checkOutput("first_an",  32'(bus.an),  32'h2);
    checkOutput("first_seg", 32'(bus.seg), 32'h40);
    repeat (DIV) applyStimulus(4'd0, 1'b0);
    checkOutput("tens_an", 32'(bus.an), 32'h1);
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("tens0_seg", 32'(bus.seg), 32'h7F);
`else
    checkOutput("tens0_seg", 32'(bus.seg), 32'h40);
`endif

    // Counting 0..9 then 0 bumps tens once.
    for (int v = 0; v <= 9; v++) applyStimulus(4'(v), 1'b1);
    applyStimulus(4'd0, 1'b1);
    checkOutput("count_tens", 32'(bus.tens), 32'd1);
    waitAn(2'b10, "units_window");
    checkOutput("units0_seg", 32'(bus.seg), 32'h40);

    // Overflow: 99 wraps preload, the 100th wraps tens and pulses ovf once.
    doReset();
    for (int w = 0; w < 99; w++) doWrap();
    checkOutput("pre_ovf_tens", 32'(bus.tens), 32'd9);
    doWrap();
    checkOutput("ovf_tens",  32'(bus.tens), 32'd0);
    checkOutput("ovf_pulse", 32'(bus.ovf),  32'd1);
    applyStimulus(4'd0, 1'b1);
    checkOutput("ovf_clear", 32'(bus.ovf),  32'd0);

    // Held samples never re-trigger a wrap.
    repeat (10) applyStimulus(4'd9, 1'b1);
    repeat (10) applyStimulus(4'd0, 1'b1);
    checkOutput("hold_tens", 32'(bus.tens), 32'd1);

    // Illegal code sets the sticky flag and leaves the digits alone.
    applyStimulus(4'hC, 1'b1);
    checkOutput("bad_set", 32'(bus.bad_code), 32'd1);
    repeat (2 * DIV + 2) applyStimulus(4'd0, 1'b0);
    checkOutput("bad_sticky", 32'(bus.bad_code), 32'd1);
    checkOutput("bad_tens",   32'(bus.tens),     32'd1);

    // Mid-refresh reset with tens at 7 while the tens digit is selected.
    doReset();
    checkOutput("bad_cleared", 32'(bus.bad_code), 32'd0);
    repeat (7) doWrap();
    checkOutput("seven_tens", 32'(bus.tens), 32'd7);
    waitAn(2'b10, "pre_units_window");
    waitAn(2'b01, "pre_tens_window");
    rst = 1'b1;
    applyStimulus(4'd0, 1'b0);
    checkOutput("midrst_tens", 32'(bus.tens), 32'd0);
    checkOutput("midrst_an",   32'(bus.an),   32'h3);
    rst = 1'b0;
    applyStimulus(4'd0, 1'b0);
    checkOutput("restart_an", 32'(bus.an), 32'h2);
    repeat (DIV) applyStimulus(4'd0, 1'b0);
    checkOutput("restart_tens_an", 32'(bus.an), 32'h1);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
